// File: rtl/sub_flag_unit.sv
// Multi-cycle subtract-and-flag stage: diff = a - b computed CHUNK bits per cycle with a rippled borrow.
// Latency: N = WIDTH/CHUNK cycles from accept to out_valid; initiation interval N+2.
// Backpressure: results held in DONE until out_ready; no accept while busy (in_ready low).
module sub_flag_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8   // WIDTH must be a multiple of CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             zf,
  output logic             nz,
  output logic             cf,
  output logic             of
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] nb_q;      // subtrahend stored inverted: a - b == a + ~b + 1
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;   // carry of the add form; borrow is its complement
  logic [KW-1:0]    k_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             zf_q;
  logic             nz_q;
  logic             cf_q;
  logic             of_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] nb_sl;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] diff_d;
  logic             of_d;

  // Current slice add, plus the full result with the in-flight slice merged in for the final load.
  always_comb begin
    a_sl      = a_q[int'(k_q)*CHUNK +: CHUNK];
    nb_sl     = nb_q[int'(k_q)*CHUNK +: CHUNK];
    slice_sum = {1'b0, a_sl} + {1'b0, nb_sl} + {{CHUNK{1'b0}}, carry_q};
    diff_d    = acc_q;
    diff_d[int'(k_q)*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
    // Operand signs differ (a vs. real b, i.e. a equals ~b in the MSB) and result sign flipped.
    of_d      = (a_q[WIDTH-1] == nb_q[WIDTH-1]) & (diff_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Control FSM with registered handshake outputs, slice datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      zf_q        <= 1'b0;
      nz_q        <= 1'b0;
      cf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            nb_q       <= ~b;
            acc_q      <= '0;
            carry_q    <= 1'b1;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q[int'(k_q)*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
          carry_q <= slice_sum[CHUNK];
          k_q     <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            diff_q      <= diff_d;
            zf_q        <= (diff_d == '0);
            nz_q        <= (diff_d != '0);
            cf_q        <= ~slice_sum[CHUNK];
            of_q        <= of_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign zf        = zf_q;
  assign nz        = nz_q;
  assign cf        = cf_q;
  assign of        = of_q;

endmodule

// File: tb/tb_sub_flag_unit.sv
// Directed bench for sub_flag_unit: vector table plus backpressure, mid-op reset and back-to-back sequences.
// Drives and samples 1 time unit after each rising edge.
// Every wait on the DUT is bounded; an expired bound counts as a failed check.
module tb_sub_flag_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = 4;   // WIDTH/CHUNK with the default CHUNK of 8

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             zf, nz, cf, of;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  sub_flag_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .zf        (zf),
    .nz        (nz),
    .cf        (cf),
    .of        (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic        zf;
    logic        nz;
    logic        cf;
    logic        of;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until in_ready is seen high at a sample point.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) chk({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Wait (bounded) for out_valid; returns number of edges waited.
  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    if (out_valid !== 1'b1) chk({name, "_valid_timeout"}, 32'(out_valid), 32'd1);
  endtask

  function automatic vec_t model(input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    v.a    = x;
    v.b    = y;
    v.diff = x - y;
    v.zf   = (v.diff == 32'd0);
    v.nz   = ~v.zf;
    v.cf   = (x < y);
    v.of   = (x[31] != y[31]) && (v.diff[31] != x[31]);
    return v;
  endfunction

  task automatic chk_result(input string name, input vec_t v);
    chk({name, "_diff"}, diff, v.diff);
    chk({name, "_zf"}, 32'(zf), 32'(v.zf));
    chk({name, "_nz"}, 32'(nz), 32'(v.nz));
    chk({name, "_cf"}, 32'(cf), 32'(v.cf));
    chk({name, "_of"}, 32'(of), 32'(v.of));
  endtask

  vec_t vt[8];

  initial begin
    int   lat;
    int   acc_cyc[3];
    vec_t v;
    logic [31:0] held_diff;
    logic [3:0]  held_flags;
    logic [31:0] bb_a[3];
    logic [31:0] bb_b[3];

    // Hand-computed vectors: {a, b, diff, zf, nz, cf, of}
    vt[0] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b1};
    vt[6] = '{32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7] = '{32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_diff", diff, 32'd0);
    chk("rst_flags", {28'd0, zf, nz, cf, of}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table: accept, scramble operands after accept, check latency, result and handshake.
    for (int i = 0; i < 8; i++) begin
      wait_ready("tbl");
      a        = vt[i].a;
      b        = vt[i].b;
      in_valid = 1'b1;
      tick();                         // accept edge
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      chk("tbl_busy_in_ready", 32'(in_ready), 32'd0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 30) begin
        if (lat > 0) tick();
        else tick();
        lat++;
      end
      chk($sformatf("tbl%0d_latency", i), lat, LAT);
      chk_result($sformatf("tbl%0d", i), vt[i]);
      tick();                         // handshake edge
      chk($sformatf("tbl%0d_valid_drop", i), 32'(out_valid), 32'd0);
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
      chk_result($sformatf("tbl%0d_hold", i), vt[i]);
    end

    // Backpressure: stall in DONE for 6 cycles while a new request is pending.
    out_ready = 1'b0;
    wait_ready("bp");
    a        = 32'hDEADBEEF;
    b        = 32'h0000BEEF;
    in_valid = 1'b1;
    tick();
    a        = 32'h00000005;             // pending request, must wait for in_ready
    b        = 32'h00000007;
    wait_valid("bp", lat);
    v = model(32'hDEADBEEF, 32'h0000BEEF);
    chk_result("bp_first", v);
    held_diff  = diff;
    held_flags = {zf, nz, cf, of};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
      chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
      chk("bp_stall_diff", diff, held_diff);
      chk("bp_stall_flags", 32'({zf, nz, cf, of}), 32'(held_flags));
    end
    out_ready = 1'b1;
    tick();                              // handshake edge
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    tick();                              // pending request accepted here
    in_valid = 1'b0;
    chk("bp_new_accept", 32'(in_ready), 32'd0);
    wait_valid("bp2", lat);
    chk("bp2_latency", lat, LAT);
    chk_result("bp2", model(32'h00000005, 32'h00000007));
    tick();

    // Reset during the second CALC cycle aborts the operation.
    wait_ready("rst");
    a        = 32'h00001234;
    b        = 32'h00000034;
    in_valid = 1'b1;
    tick();                              // accept; first CALC cycle
    in_valid = 1'b0;
    tick();                              // second CALC cycle
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_diff", diff, 32'd0);
    chk("mid_rst_flags", {28'd0, zf, nz, cf, of}, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_result", 32'(out_valid), 32'd0);
    end
    a        = 32'h00000003;
    b        = 32'h00000005;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("post_rst", lat);
    chk("post_rst_latency", lat, LAT);
    chk_result("post_rst", model(32'h00000003, 32'h00000005));
    tick();

    // Back-to-back with in_valid held high: accepts every N+2 cycles.
    bb_a[0] = 32'hFFFFFFFF; bb_b[0] = 32'h00000001;
    bb_a[1] = 32'h00000000; bb_b[1] = 32'h80000000;
    bb_a[2] = 32'hA5A5A5A5; bb_b[2] = 32'h5A5A5A5A;
    wait_ready("bb");
    a        = bb_a[0];
    b        = bb_b[0];
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready("bb_loop");
      tick();                            // accept edge
      acc_cyc[i] = cyc;
      if (i < 2) begin
        a = bb_a[i+1];
        b = bb_b[i+1];
      end else begin
        in_valid = 1'b0;
      end
      wait_valid("bb_loop", lat);
      chk_result($sformatf("bb%0d", i), model(bb_a[i], bb_b[i]));
      tick();                            // handshake edge
      if (i > 0) chk($sformatf("bb%0d_spacing", i), acc_cyc[i] - acc_cyc[i-1], LAT + 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
